// File: rtl/tea_pkg.sv
// Shared TEA constants and types for the encrypt/decrypt pair.
// The decrypt stage starts from TEA_SUM_FINAL and walks the sum back down.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA     = 32'h9E37_79B9;
  localparam int          TEA_ROUNDS    = 32;
  localparam logic [31:0] TEA_SUM_FINAL = 32'hC6EF_3720;

  // Packed so that k0 lands in bits [31:0] of the flat 128-bit key.
  typedef struct packed {
    logic [31:0] k3;
    logic [31:0] k2;
    logic [31:0] k1;
    logic [31:0] k0;
  } tea_key_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tea_state_t;

  typedef struct packed {
    tea_state_t  state;
    logic [5:0]  cnt;
    logic [31:0] sum;
  } tea_dbg_t;

  // One TEA half-round mixing term: ((v<<4)+ka) ^ (v+s) ^ ((v>>5)+kb).
  function automatic logic [31:0] tea_mix(input logic [31:0] v,
                                          input logic [31:0] ka,
                                          input logic [31:0] kb,
                                          input logic [31:0] s);
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_encrypt_if.sv
// Block-level handshake bundle for tea_encrypt.
// Both ports use valid/ready: a transfer happens on the rising edge where valid && ready.
interface tea_encrypt_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_v0;
  logic [31:0]  in_v1;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_v0;
  logic [31:0]  out_v1;
  logic         busy;

  modport master (
    output in_valid, in_v0, in_v1, in_key, out_ready,
    input  in_ready, out_valid, out_v0, out_v1, busy
  );

  modport slave (
    input  in_valid, in_v0, in_v1, in_key, out_ready,
    output in_ready, out_valid, out_v0, out_v1, busy
  );
endinterface

// File: rtl/tea_round.sv
// One full TEA Feistel cycle, purely combinational.
// The second half-round consumes the freshly updated v0.
module tea_round
  import tea_pkg::*;
(
  input  logic [31:0] v0,
  input  logic [31:0] v1,
  input  logic [31:0] sum,
  input  tea_key_t    key,
  output logic [31:0] v0_next,
  output logic [31:0] v1_next,
  output logic [31:0] sum_next
);

  always_comb begin
    sum_next = sum + TEA_DELTA;
    v0_next  = v0 + tea_mix(v1, key.k0, key.k1, sum_next);
    v1_next  = v1 + tea_mix(v0_next, key.k2, key.k3, sum_next);
  end

endmodule

// File: rtl/tea_encrypt.sv
// Iterative TEA encryptor: accepts a block in IDLE, runs ROUNDS cycles in RUN,
// and holds the ciphertext in DONE until the consumer takes it.
module tea_encrypt
  import tea_pkg::*;
#(
  parameter int ROUNDS = TEA_ROUNDS
) (
  input  logic                clk,
  input  logic                reset,
  tea_encrypt_if.slave        bus,
  output tea_dbg_t            dbg
);

  tea_state_t  state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] sum_q, v0_q, v1_q;
  tea_key_t    key_q;
  logic [31:0] r_v0, r_v1, r_sum;
  logic        last_round;

  tea_round u_round (
    .v0       (v0_q),
    .v1       (v1_q),
    .sum      (sum_q),
    .key      (key_q),
    .v0_next  (r_v0),
    .v1_next  (r_v1),
    .sum_next (r_sum)
  );

  assign last_round = (cnt_q == 6'(ROUNDS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last_round)    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      v0_q    <= '0;
      v1_q    <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.in_valid) begin
          v0_q  <= bus.in_v0;
          v1_q  <= bus.in_v1;
          key_q <= tea_key_t'(bus.in_key);
          sum_q <= '0;
          cnt_q <= '0;
        end
        RUN: begin
          v0_q  <= r_v0;
          v1_q  <= r_v1;
          sum_q <= r_sum;
          cnt_q <= cnt_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Ready is masked while reset is asserted so nothing is offered during the reset cycle.
  assign bus.in_ready  = (state_q == IDLE) && !reset;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_v0    = v0_q;
  assign bus.out_v1    = v1_q;

  assign dbg.state = state_q;
  assign dbg.cnt   = cnt_q;
  assign dbg.sum   = sum_q;

endmodule

// File: tb/tb_tea_encrypt.sv
// Directed bench for tea_encrypt: known-answer vectors, output stall,
// input churn during RUN, mid-block reset and back-to-back streaming.
module tb_tea_encrypt;
  import tea_pkg::*;

  typedef struct {
    logic [31:0]  v0;
    logic [31:0]  v1;
    logic [127:0] key;
    logic [31:0]  e0;
    logic [31:0]  e1;
  } vec_t;

  logic     clk = 1'b0;
  logic     reset;
  tea_dbg_t dbg;
  int       cyc = 0;
  int       n_tests = 0;
  int       n_fail = 0;
  int       acc_cyc;
  bit       sb_on = 1'b0;
  logic [63:0] exp_q[$];
  vec_t     vecs[2];

  tea_encrypt_if bus();

  tea_encrypt #(.ROUNDS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .dbg   (dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent inverse cipher, standing in for the downstream decrypt stage.
  function automatic logic [63:0] tea_decrypt(input logic [31:0] c0, input logic [31:0] c1,
                                              input logic [127:0] k);
    logic [31:0] a, b, s;
    a = c0; b = c1; s = 32'hC6EF3720;
    for (int i = 0; i < 32; i++) begin
      b = b - (((a << 4) + k[95:64]) ^ (a + s) ^ ((a >> 5) + k[127:96]));
      a = a - (((b << 4) + k[31:0]) ^ (b + s) ^ ((b >> 5) + k[63:32]));
      s = s - 32'h9E3779B9;
    end
    return {a, b};
  endfunction

  // Scoreboard: every output transfer must match the oldest accepted block.
  always @(negedge clk) begin
    if (sb_on && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_xfer", 64'd1, 64'd0);
      else check("sb_data", {bus.out_v0, bus.out_v1}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input vec_t v, input bit keep_valid);
    int t;
    bus.in_v0 = v.v0; bus.in_v1 = v.v1; bus.in_key = v.key;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk); t++;
    end
    if (!bus.in_ready) check("accept_timeout", 64'd1, 64'd0);
    @(negedge clk);
    acc_cyc = cyc;
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    int t;
    t = 0;
    while (!bus.out_valid && t < 100) begin
      @(negedge clk); t++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 64'd1, 64'd0);
    lat = cyc - acc_cyc;
  endtask

  task automatic finish_xfer(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_idle"}, {63'd0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    int lat;
    int acc_prev;
    logic [63:0] held;

    vecs[0] = '{32'h12345678, 32'h9ABCDEF0, 128'h44444444_33333333_22222222_11111111,
                32'h5CF85E83, 32'hE967E1FD};
    vecs[1] = '{32'h0, 32'h0, 128'h0, 32'h41EA3A0A, 32'h94BAA940};

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_v0 = '0; bus.in_v1 = '0; bus.in_key = '0;
    bus.out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_out_data", {bus.out_v0, bus.out_v1}, 64'd0);
    check("rst_sum_cnt", {26'd0, dbg.cnt, dbg.sum}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Known-answer vectors.
    for (int i = 0; i < 2; i++) begin
      send(vecs[i], 1'b0);
      wait_valid(lat);
      check($sformatf("kat%0d_latency", i), 64'(lat), 64'd32);
      check($sformatf("kat%0d_sum", i), 64'(dbg.sum), 64'(TEA_SUM_FINAL));
      check($sformatf("kat%0d_data", i), {bus.out_v0, bus.out_v1}, {vecs[i].e0, vecs[i].e1});
      check($sformatf("kat%0d_decrypt", i),
            tea_decrypt(bus.out_v0, bus.out_v1, vecs[i].key), {vecs[i].v0, vecs[i].v1});
      finish_xfer($sformatf("kat%0d", i));
    end

    // Output stall with input churn in DONE.
    send(vecs[0], 1'b0);
    wait_valid(lat);
    held = {bus.out_v0, bus.out_v1};
    check("stall_data", held, {vecs[0].e0, vecs[0].e1});
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.in_v0 = $urandom;
      bus.in_key = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("stall_hold", {bus.out_v0, bus.out_v1}, held);
      check("stall_flags", {61'd0, bus.out_valid, bus.in_ready, bus.busy}, 64'b101);
    end
    bus.in_valid = 1'b0;
    finish_xfer("stall");
    @(negedge clk);
    check("stall_no_accept", 64'(dbg.state), 64'(IDLE));

    // Input churn during RUN must not disturb the latched block.
    send(vecs[0], 1'b0);
    for (int i = 0; i < 100 && !bus.out_valid; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_v0 = $urandom; bus.in_v1 = $urandom;
      bus.in_key = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("churn_valid", 64'(bus.out_valid), 64'd1);
    check("churn_data", {bus.out_v0, bus.out_v1}, {vecs[0].e0, vecs[0].e1});
    finish_xfer("churn");

    // Reset in the middle of a block.
    send(vecs[1], 1'b0);
    repeat (15) @(negedge clk);
    check("midrst_running", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_flags", {61'd0, bus.out_valid, bus.busy, bus.in_ready}, 64'd0);
    check("midrst_data", {bus.out_v0, bus.out_v1}, 64'd0);
    check("midrst_sum_cnt", {26'd0, dbg.cnt, dbg.sum}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(bus.in_ready), 64'd1);
    send(vecs[0], 1'b0);
    wait_valid(lat);
    check("midrst_latency", 64'(lat), 64'd32);
    check("midrst_data_after", {bus.out_v0, bus.out_v1}, {vecs[0].e0, vecs[0].e1});
    finish_xfer("midrst");

    // Back-to-back streaming with out_ready tied high and in_valid held.
    sb_on = 1'b1;
    bus.out_ready = 1'b1;
    acc_prev = 0;
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back({vecs[b % 2].e0, vecs[b % 2].e1});
      send(vecs[b % 2], 1'b1);
      if (b > 0) check($sformatf("b2b_spacing%0d", b), 64'(acc_cyc - acc_prev), 64'd34);
      acc_prev = acc_cyc;
    end
    bus.in_valid = 1'b0;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    check("b2b_drained", 64'(exp_q.size()), 64'd0);
    sb_on = 1'b0;
    bus.out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tea_encrypt.md
# tea_encrypt

Iterative TEA block encryptor that produces the 64-bit ciphertext consumed by the downstream TEA decrypt stage. It accepts one plaintext block plus a 128-bit key through a valid/ready handshake and computes one full Feistel cycle per clock. It then holds the ciphertext on a valid/ready output port until the consumer takes it. Round count and arithmetic match the decrypt stage exactly: initial decrypt sum = final encrypt sum.

## Interface
- `ROUNDS`, default 32: Feistel cycles per block, range 1..63. Only 32 interoperates with the downstream decrypt.
- `clk` in 1: single clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: a plaintext block and key are presented.
- `in_ready` out 1: the block can accept input; high only in IDLE.
- `in_v0` in 32: plaintext word 0.
- `in_v1` in 32: plaintext word 1.
- `in_key` in 128: key; k0=[31:0], k1=[63:32], k2=[95:64], k3=[127:96].
- `out_valid` out 1: ciphertext is valid.
- `out_ready` in 1: the consumer accepts the ciphertext.
- `out_v0` out 32: ciphertext word 0.
- `out_v1` out 32: ciphertext word 1.
- `busy` out 1: high in RUN or DONE.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. If `in_valid`=1, latch v0, v1, and the key; set sum=0 and cnt=0; go to RUN.
  - RUN: one cycle per clock. Go to DONE on the edge where cnt reaches ROUNDS-1.
  - DONE: `out_valid`=1. If `out_ready`=1, go to IDLE. Otherwise hold all registers.
- One cycle, all arithmetic mod 2^32:
  - s' = sum + 0x9E3779B9
  - v0' = v0 + (((v1<<4)+k0) ^ (v1+s') ^ ((v1>>5)+k1))
  - v1' = v1 + (((v0'<<4)+k2) ^ (v0'+s') ^ ((v0'>>5)+k3))
  - v1' uses the updated v0'.
- Shifts are logical. All additions wrap with no carry-out.
- The final sum equals ROUNDS·delta mod 2^32. For ROUNDS=32 this is 0xC6EF3720.
- Key and plaintext are captured only at acceptance. Input changes during RUN/DONE are ignored.
- `out_v0`/`out_v1` are the working registers. They are only guaranteed meaningful while `out_valid`=1 and are stable throughout DONE.
- `in_valid` without `in_ready` has no effect. No input is buffered.
- `cnt` is 6 bits and never wraps within legal ROUNDS.

## Timing
- Reset values: `in_ready`=0 during the reset cycle and 1 from the first post-reset cycle (state IDLE). `out_valid`=0, `busy`=0, `out_v0`=0, `out_v1`=0, sum=0, cnt=0.
- Latency: with the acceptance edge at T, `out_valid` rises after edge T+ROUNDS (33 edges including acceptance for ROUNDS=32).
- Throughput: one block per ROUNDS+2 cycles with `out_ready` tied high. There is no overlap, because `in_ready`=0 in DONE.
- Output handshake: the transfer occurs on the edge where `out_valid`&&`out_ready`. `out_valid` drops on the next cycle. If `out_ready` is low, DONE is held indefinitely with the data stable.
- Simultaneous events: in DONE, a high `in_valid` is ignored even if `out_ready` is high. The next block is accepted in IDLE at the earliest one cycle after the output transfer.
- Reset mid-operation (RUN or DONE): the current block is abandoned. All outputs return to their reset values on the next edge, and no partial ciphertext is ever presented.
- No combinational path exists from inputs to outputs. `in_ready` and `out_valid` are pure state decodes.

## Structure
- Package `tea_pkg`:
  - TEA_DELTA=0x9E3779B9.
  - TEA_ROUNDS=32.
  - TEA_SUM_FINAL=0xC6EF3720, shared with decrypt for its initial sum.
  - A 128-bit key type with k0..k3 field accessors.
  - The FSM state enum {IDLE, RUN, DONE}.
- Sub-module `tea_round`: purely combinational, mapping (v0, v1, sum, key) to (v0', v1', s'). It contains both half-rounds in the prescribed order. A future decrypt refactor can pair it with an inverse round.
- The top level holds the FSM, the counter, the working registers, and the handshake logic.

## Test plan
- Key 0x44444444_33333333_22222222_11111111, v0=0x12345678, v1=0x9ABCDEF0 -> out_v0=0x5CF85E83, out_v1=0xE967E1FD. `out_valid` rises 32 cycles after acceptance, and the internal sum is 0xC6EF3720.
- All-zero key and plaintext -> out_v0=0x41EA3A0A, out_v1=0x94BAA940.
- Hold `out_ready`=0 for 10 cycles after `out_valid`, and toggle `in_valid`/`in_v0`/`in_key` meanwhile -> data stable, `in_ready`=0, no new acceptance. Raise `out_ready` -> a one-cycle transfer, then IDLE.
- Change `in_key` and `in_v0` every cycle during RUN -> the result still equals the vector latched at acceptance.
- Assert `reset` for one cycle at round 15 -> all outputs are 0 the next cycle and `in_ready`=1 after reset releases. A fresh block then produces the first vector correctly.
- Back-to-back blocks with `out_ready`=1 and `in_valid` held high -> acceptances spaced exactly 34 cycles apart, with each ciphertext correct. Chain the output into the decrypt stage -> v1 returns 0x9ABCDEF0.
